// File: rtl/icw_initialization_sequencer.sv
// icw_initialization_sequencer
// Decodes CPU writes into ICW1-ICW4 / OCW1-OCW3 for the 8259A control logic,
// tracks the ICW sequence with a small FSM and holds the ICW configuration.
// Optional feature macro: ICW_SEQUENCE_ERROR_EN adds a sticky sequence_error
// output flagging a0=0 non-ICW1 writes received before initialization ends.
module icw_initialization_sequencer #(
    parameter int VECTOR_WIDTH  = 5,
    parameter int CASCADE_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     write_enable,
    input  logic                     a0,
    input  logic [7:0]               internal_data_bus,
    output logic                     write_initial_command_word_1,
    output logic                     write_initial_command_word_2,
    output logic                     write_initial_command_word_3,
    output logic                     write_initial_command_word_4,
    output logic                     write_operation_control_word_1,
    output logic                     write_operation_control_word_2,
    output logic                     write_operation_control_word_3,
    output logic                     level_or_edge_triggered_config,
    output logic                     call_address_interval_4_or_8_config,
    output logic                     single_or_cascade_config,
    output logic [VECTOR_WIDTH-1:0]  interrupt_vector_address,
    output logic [CASCADE_WIDTH-1:0] cascade_device_config,
    output logic                     special_fully_nest_config,
    output logic                     buffered_mode_config,
    output logic                     buffered_master_or_slave_config,
    output logic                     auto_eoi_config,
    output logic                     u8086_or_mcs80_config,
    output logic                     initialization_complete
`ifdef ICW_SEQUENCE_ERROR_EN
    ,
    output logic                     sequence_error
`endif
);

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       ic4;
    logic [4:0] icw4_bits;

    logic is_icw1;
    logic data_write;
    logic icw2_next, icw3_next, icw4_next;
    logic ocw1_next, ocw2_next, ocw3_next;
    logic error_set;

    // ICW1 restarts the sequence from any state; a0=1 writes carry ICW2-4/OCW1
    always_comb begin
        is_icw1    = write_enable & ~a0 & internal_data_bus[4];
        data_write = write_enable & a0;
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= UNINIT;
        else          state <= next_state;
    end

    // Next-state logic: skip ICW3 in single mode and ICW4 when IC4 is clear
    always_comb begin
        next_state = state;
        if (is_icw1) begin
            next_state = WAIT_ICW2;
        end else if (data_write) begin
            case (state)
                WAIT_ICW2: begin
                    if (!single_or_cascade_config) next_state = WAIT_ICW3;
                    else if (ic4)                  next_state = WAIT_ICW4;
                    else                           next_state = READY;
                end
                WAIT_ICW3: next_state = ic4 ? WAIT_ICW4 : READY;
                WAIT_ICW4: next_state = READY;
                default:   next_state = state;
            endcase
        end
    end

    // Output decode: which strobe the current write will raise next cycle
    always_comb begin
        icw2_next = data_write & (state == WAIT_ICW2);
        icw3_next = data_write & (state == WAIT_ICW3);
        icw4_next = data_write & (state == WAIT_ICW4);
        ocw1_next = data_write & (state == READY);
        ocw2_next = write_enable & ~a0 & (internal_data_bus[4:3] == 2'b00) & (state == READY);
        ocw3_next = write_enable & ~a0 & (internal_data_bus[4:3] == 2'b01) & (state == READY);
        error_set = write_enable & ~a0 & ~internal_data_bus[4] & (state != READY);
    end

    // Registered one-cycle strobes
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            write_initial_command_word_1   <= 1'b0;
            write_initial_command_word_2   <= 1'b0;
            write_initial_command_word_3   <= 1'b0;
            write_initial_command_word_4   <= 1'b0;
            write_operation_control_word_1 <= 1'b0;
            write_operation_control_word_2 <= 1'b0;
            write_operation_control_word_3 <= 1'b0;
        end else begin
            write_initial_command_word_1   <= is_icw1;
            write_initial_command_word_2   <= icw2_next;
            write_initial_command_word_3   <= icw3_next;
            write_initial_command_word_4   <= icw4_next;
            write_operation_control_word_1 <= ocw1_next;
            write_operation_control_word_2 <= ocw2_next;
            write_operation_control_word_3 <= ocw3_next;
        end
    end

    // ICW configuration storage; ICW1 clears ICW3/ICW4 so skipped words read 0
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            level_or_edge_triggered_config      <= 1'b0;
            call_address_interval_4_or_8_config <= 1'b0;
            single_or_cascade_config            <= 1'b0;
            ic4                                 <= 1'b0;
            interrupt_vector_address            <= '0;
            cascade_device_config               <= '0;
            icw4_bits                           <= 5'd0;
        end else if (is_icw1) begin
            level_or_edge_triggered_config      <= internal_data_bus[3];
            call_address_interval_4_or_8_config <= internal_data_bus[2];
            single_or_cascade_config            <= internal_data_bus[1];
            ic4                                 <= internal_data_bus[0];
            cascade_device_config               <= '0;
            icw4_bits                           <= 5'd0;
        end else begin
            if (icw2_next) interrupt_vector_address <= internal_data_bus[7 -: VECTOR_WIDTH];
            if (icw3_next) cascade_device_config    <= internal_data_bus[CASCADE_WIDTH-1:0];
            if (icw4_next) icw4_bits                <= internal_data_bus[4:0];
        end
    end

    // ICW4 field breakout and READY indication
    always_comb begin
        special_fully_nest_config       = icw4_bits[4];
        buffered_mode_config            = icw4_bits[3];
        buffered_master_or_slave_config = icw4_bits[2];
        auto_eoi_config                 = icw4_bits[1];
        u8086_or_mcs80_config           = icw4_bits[0];
        initialization_complete         = (state == READY);
    end

`ifdef ICW_SEQUENCE_ERROR_EN
    // Sticky error flag, cleared only by ICW1 or reset
    always_ff @(posedge clock) begin
        if (!reset_n)       sequence_error <= 1'b0;
        else if (is_icw1)   sequence_error <= 1'b0;
        else if (error_set) sequence_error <= 1'b1;
    end
`else
    // Error detection is not built; keep the decode term referenced
    logic unused_error;
    always_comb unused_error = error_set;
`endif

endmodule

// File: tb/tb_icw_initialization_sequencer.sv
// Testbench for icw_initialization_sequencer: directed test-plan sequences
// followed by randomized writes checked against a queue-based sequence model.
module tb_icw_initialization_sequencer;

    localparam int VW = 5;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          write_enable = 1'b0;
    logic          a0 = 1'b0;
    logic [7:0]    internal_data_bus = 8'h00;
    logic          icw1_s, icw2_s, icw3_s, icw4_s, ocw1_s, ocw2_s, ocw3_s;
    logic          ltim, adi, sngl;
    logic [VW-1:0] vec;
    logic [CW-1:0] cas;
    logic          sfnm, buf_m, ms, aeoi, upm;
    logic          complete;
`ifdef ICW_SEQUENCE_ERROR_EN
    logic          seq_err;
`endif

    icw_initialization_sequencer #(.VECTOR_WIDTH(VW), .CASCADE_WIDTH(CW)) dut (
        .clock                               (clock),
        .reset_n                             (reset_n),
        .write_enable                        (write_enable),
        .a0                                  (a0),
        .internal_data_bus                   (internal_data_bus),
        .write_initial_command_word_1        (icw1_s),
        .write_initial_command_word_2        (icw2_s),
        .write_initial_command_word_3        (icw3_s),
        .write_initial_command_word_4        (icw4_s),
        .write_operation_control_word_1      (ocw1_s),
        .write_operation_control_word_2      (ocw2_s),
        .write_operation_control_word_3      (ocw3_s),
        .level_or_edge_triggered_config      (ltim),
        .call_address_interval_4_or_8_config (adi),
        .single_or_cascade_config            (sngl),
        .interrupt_vector_address            (vec),
        .cascade_device_config               (cas),
        .special_fully_nest_config           (sfnm),
        .buffered_mode_config                (buf_m),
        .buffered_master_or_slave_config     (ms),
        .auto_eoi_config                     (aeoi),
        .u8086_or_mcs80_config               (upm),
        .initialization_complete             (complete)
`ifdef ICW_SEQUENCE_ERROR_EN
        ,
        .sequence_error                      (seq_err)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: pending ICW numbers still owed in the current sequence
    bit            m_init;
    int            m_pend[$];
    bit            m_ltim, m_adi, m_sngl;
    logic [VW-1:0] m_vec;
    logic [CW-1:0] m_cas;
    logic [4:0]    m_icw4;
    int            m_strobe;   // 0 none, 1..4 ICWn, 5..7 OCW1..3
    bit            m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit we, input bit ad, input logic [7:0] d);
        m_strobe = 0;
        if (!rst) begin
            m_init = 0; m_pend.delete();
            m_ltim = 0; m_adi = 0; m_sngl = 0;
            m_vec = '0; m_cas = '0; m_icw4 = '0; m_err = 0;
        end else if (we) begin
            if (!ad && d[4]) begin
                m_ltim = d[3]; m_adi = d[2]; m_sngl = d[1];
                m_icw4 = '0; m_cas = '0; m_err = 0;
                m_pend.delete();
                m_pend.push_back(2);
                if (!d[1]) m_pend.push_back(3);
                if (d[0])  m_pend.push_back(4);
                m_init = 1; m_strobe = 1;
            end else if (m_init && m_pend.size() == 0) begin
                if (ad)        m_strobe = 5;
                else if (!d[3]) m_strobe = 6;
                else           m_strobe = 7;
            end else if (ad) begin
                if (m_init) begin
                    int n;
                    n = m_pend.pop_front();
                    m_strobe = n;
                    if (n == 2) m_vec = VW'(d >> (8 - VW));
                    if (n == 3) m_cas = d[CW-1:0];
                    if (n == 4) m_icw4 = d[4:0];
                end
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit we, input bit ad, input logic [7:0] d);
        logic [6:0] exp_s;
        @(negedge clock);
        reset_n = rst; write_enable = we; a0 = ad; internal_data_bus = d;
        @(posedge clock);
        model_step(rst, we, ad, d);
        #1;
        exp_s = (m_strobe == 0) ? 7'd0 : 7'(1 << (m_strobe - 1));
        check("strobes", {ocw3_s, ocw2_s, ocw1_s, icw4_s, icw3_s, icw2_s, icw1_s}, exp_s);
        check("icw1_cfg", {ltim, adi, sngl}, {m_ltim, m_adi, m_sngl});
        check("vector", vec, m_vec);
        check("cascade", cas, m_cas);
        check("icw4", {sfnm, buf_m, ms, aeoi, upm}, m_icw4);
        check("complete", complete, m_init && m_pend.size() == 0);
`ifdef ICW_SEQUENCE_ERROR_EN
        check("seq_err", seq_err, m_err);
`endif
    endtask

    initial begin
        cycle(0, 0, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);
        check("reset_complete", complete, 0);

        // ICW1 edge/single/IC4, ICW2, ICW4
        cycle(1, 1, 0, 8'h13);
        check("icw1_strobe", icw1_s, 1);
        cycle(1, 1, 1, 8'h48);
        check("vector_0x48", vec, 5'h09);
        check("no_icw3", icw3_s, 0);
        check("not_ready_yet", complete, 0);
        cycle(1, 1, 1, 8'h1F);
        check("icw4_strobe", icw4_s, 1);
        check("icw4_all", {sfnm, buf_m, ms, aeoi, upm}, 5'h1F);
        check("ready_after_icw4", complete, 1);

        // Cascade with IC4
        cycle(1, 1, 0, 8'h11);
        cycle(1, 1, 1, 8'h20);
        cycle(1, 1, 1, 8'h04);
        check("icw3_strobe", icw3_s, 1);
        cycle(1, 1, 1, 8'h01);
        check("cascade_04", cas, 8'h04);
        check("icw4_upm_only", {sfnm, buf_m, ms, aeoi, upm}, 5'h01);
        check("ready_cascade", complete, 1);

        // Single, no IC4
        cycle(1, 1, 0, 8'h1A);
        cycle(1, 1, 1, 8'h08);
        check("ready_after_icw2", complete, 1);
        check("icw4_zero", {sfnm, buf_m, ms, aeoi, upm}, 5'h00);
        check("ltim_sngl", {ltim, sngl}, 2'b11);

        // OCWs back to back
        cycle(1, 1, 1, 8'hFF);
        check("ocw1", ocw1_s, 1);
        cycle(1, 1, 0, 8'h20);
        check("ocw2", ocw2_s, 1);
        cycle(1, 1, 0, 8'h0B);
        check("ocw3", ocw3_s, 1);
        check("vector_kept", vec, 5'h01);

        // Abort in WAIT_ICW4
        cycle(1, 1, 0, 8'h13);
        cycle(1, 1, 1, 8'h48);
        cycle(1, 1, 1, 8'h1F);
        cycle(1, 1, 0, 8'h13);
        cycle(1, 1, 1, 8'h48);
        cycle(1, 1, 0, 8'h10);
        check("abort_icw4_clear", {sfnm, buf_m, ms, aeoi, upm}, 5'h00);
        check("abort_not_ready", complete, 0);
        cycle(0, 1, 0, 8'h13);
        check("rst_with_write_s", icw1_s, 0);
        check("rst_cfg", {ltim, adi, sngl}, 3'b000);

`ifdef ICW_SEQUENCE_ERROR_EN
        cycle(1, 1, 0, 8'h13);
        cycle(1, 1, 0, 8'h20);
        check("err_set", seq_err, 1);
        cycle(1, 0, 0, 8'h00);
        check("err_sticky", seq_err, 1);
        cycle(1, 1, 0, 8'h13);
        check("err_clear", seq_err, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit         rst, we, ad;
            logic [7:0] d;
            rst = ($urandom_range(0, 49) != 0);
            we  = ($urandom_range(0, 3) != 0);
            ad  = $urandom_range(0, 1);
            d   = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                ad = 0;
                d[4] = 1'b1;
            end
            cycle(rst, we, ad, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
